// File: rtl/aes_sbox_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox_arbiter (with helper aes_sub_byte)
// Purpose  : Shares one combinational AES S-box between NREQ byte requesters.
//            Round-robin arbitration with burst locking, and a single
//            registered response stage with backpressure.
// Ports    : clk, rst_n           - clock, async active-low reset
//            i_req_valid/byte/last - per-requester byte handshake inputs
//            o_req_ready          - per-requester accept (one-hot or zero)
//            o_rsp_valid/byte/id/last, i_rsp_ready - response handshake
//            o_busy               - burst lock held or response pending
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// aes_sub_byte: combinational FIPS-197 SubBytes for one byte.
// The multiplicative inverse is computed as x^254 in GF(2^8), followed by the
// standard affine transform. Zero maps to zero before the affine step.
// ----------------------------------------------------------------------------
module aes_sub_byte (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [7:0] c_affine = 8'h63;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      // Multiply by x modulo x^8 + x^4 + x^3 + x + 1
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  logic [7:0] w_inv;

  always_comb begin
    w_inv  = gf_inv(i_byte);
    o_byte = 8'h00;
    for (int i = 0; i < 8; i++) begin
      o_byte[i] = w_inv[i] ^ w_inv[(i + 4) % 8] ^ w_inv[(i + 5) % 8]
                ^ w_inv[(i + 6) % 8] ^ w_inv[(i + 7) % 8] ^ c_affine[i];
    end
  end

endmodule

// ----------------------------------------------------------------------------
// aes_sbox_arbiter: top level
// ----------------------------------------------------------------------------
module aes_sbox_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [NREQ*8-1:0] i_req_byte,
  input  logic [NREQ-1:0]   i_req_last,
  output logic [NREQ-1:0]   o_req_ready,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [7:0]        o_rsp_byte,
  output logic [IDW-1:0]    o_rsp_id,
  output logic              o_rsp_last,
  output logic              o_busy
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_owner;
  logic [IDW-1:0] w_owner_nxt;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] w_rr_ptr_nxt;

  logic           r_rsp_valid;
  logic [7:0]     r_rsp_byte;
  logic [IDW-1:0] r_rsp_id;
  logic           r_rsp_last;

  logic [IDW-1:0] w_gnt_idx;
  logic           w_gnt_any;
  logic           w_can_acc;
  logic           w_xfer;
  logic [7:0]     w_sel_byte;
  logic           w_sel_last;
  logic [7:0]     w_sub_byte;

  assign w_can_acc = !r_rsp_valid || i_rsp_ready;
  // rst_n gates the transfer so req_ready is held low during reset.
  assign w_xfer    = rst_n && w_gnt_any && w_can_acc;

  // Grant selection: locked owner, or first valid requester from rr_ptr.
  always_comb begin : p_arb
    int             j;
    logic [IDW-1:0] idx;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    j         = 0;
    idx       = '0;
    if (r_state == ST_LOCKED) begin
      w_gnt_idx = r_owner;
      w_gnt_any = i_req_valid[r_owner];
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        j = int'(r_rr_ptr) + k;
        if (j >= NREQ) j = j - NREQ;
        idx = IDW'(j);
        if (!w_gnt_any && i_req_valid[idx]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = idx;
        end
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (w_xfer) o_req_ready[w_gnt_idx] = 1'b1;
  end

  // S-box input mux; defaults to index 0 when nothing is granted.
  always_comb begin
    w_sel_byte = i_req_byte[7:0];
    w_sel_last = i_req_last[0];
    for (int k = 0; k < NREQ; k++) begin
      if (w_gnt_any && (IDW'(k) == w_gnt_idx)) begin
        w_sel_byte = i_req_byte[k*8 +: 8];
        w_sel_last = i_req_last[k];
      end
    end
  end

  aes_sub_byte u_sbox (
    .i_byte (w_sel_byte),
    .o_byte (w_sub_byte)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // FSM next state. rr_ptr advances only when a burst completes, so a whole
  // burst counts as a single round-robin turn.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_xfer) begin
      if (w_sel_last) begin
        w_state_nxt  = ST_IDLE;
        w_rr_ptr_nxt = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      end else begin
        w_state_nxt = ST_LOCKED;
        w_owner_nxt = w_gnt_idx;
      end
    end
  end

  // Response register: a new load takes priority over a consume, which
  // keeps rsp_valid high without a bubble when both happen together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_byte  <= 8'h00;
      r_rsp_id    <= '0;
      r_rsp_last  <= 1'b0;
    end else if (w_xfer) begin
      r_rsp_valid <= 1'b1;
      r_rsp_byte  <= w_sub_byte;
      r_rsp_id    <= w_gnt_idx;
      r_rsp_last  <= w_sel_last;
    end else if (r_rsp_valid && i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_byte  = r_rsp_byte;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_last  = r_rsp_last;
  assign o_busy      = (r_state == ST_LOCKED) || r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_aes_sbox_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_sbox_arbiter
// Purpose  : Directed testbench for aes_sbox_arbiter (NREQ=2). Expected
//            responses are queued by the stimulus; a monitor pops and compares
//            on every consumed response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_sbox_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  // FIPS-197 S-box, byte 0 at the most significant end.
  localparam logic [0:2047] SBOX_REF = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef struct packed {
    logic [7:0]     b;
    logic [IDW-1:0] id;
    logic           last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   i_req_valid;
  logic [NREQ*8-1:0] i_req_byte;
  logic [NREQ-1:0]   i_req_last;
  logic [NREQ-1:0]   o_req_ready;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [7:0]        o_rsp_byte;
  logic [IDW-1:0]    o_rsp_id;
  logic              o_rsp_last;
  logic              o_busy;

  logic       tb_v [NREQ];
  logic [7:0] tb_b [NREQ];
  logic       tb_l [NREQ];

  exp_t sb [$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   w0, w1, c0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    i_req_valid = '0;
    i_req_last  = '0;
    i_req_byte  = '0;
    for (int k = 0; k < NREQ; k++) begin
      i_req_valid[k]       = tb_v[k];
      i_req_last[k]        = tb_l[k];
      i_req_byte[k*8 +: 8] = tb_b[k];
    end
  end

  aes_sbox_arbiter #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (i_req_valid),
    .i_req_byte  (i_req_byte),
    .i_req_last  (i_req_last),
    .o_req_ready (o_req_ready),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_byte  (o_rsp_byte),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_last  (o_rsp_last),
    .o_busy      (o_busy)
  );

  function automatic logic [7:0] sref(input int v);
    logic [0:2047] t;
    t = SBOX_REF;
    return t[v*8 +: 8];
  endfunction

  task automatic expect_rsp(input logic [7:0] in, input int id, input logic last);
    sb.push_back('{b: sref(int'(in)), id: IDW'(id), last: last});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one byte on requester r; returns at posedge+1 after acceptance.
  task automatic drive(input int r, input logic [7:0] b, input logic last, output int waits);
    tb_v[r] = 1'b1;
    tb_b[r] = b;
    tb_l[r] = last;
    waits   = 0;
    forever begin
      @(negedge clk);
      if (o_req_ready[r]) break;
      waits++;
      if (waits > 300) begin
        checks++;
        errors++;
        $display("FAIL drive_timeout: req%0d byte 0x%0h never accepted", r, b);
        break;
      end
    end
    @(posedge clk);
    #1;
    tb_v[r] = 1'b0;
  endtask

  // Monitor: compare every consumed response against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && o_rsp_valid && i_rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got byte 0x%0h id %0d with empty queue", o_rsp_byte, o_rsp_id);
      end else begin
        mon_e = sb.pop_front();
        if (o_rsp_byte !== mon_e.b || o_rsp_id !== mon_e.id || o_rsp_last !== mon_e.last) begin
          errors++;
          $display("FAIL rsp_data: got byte 0x%0h id %0d last %0b expected byte 0x%0h id %0d last %0b",
                   o_rsp_byte, o_rsp_id, o_rsp_last, mon_e.b, mon_e.id, mon_e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    i_rsp_ready = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      tb_v[k] = 1'b0;
      tb_b[k] = 8'h00;
      tb_l[k] = 1'b0;
    end

    // Reset state; a valid request must not see ready during reset
    repeat (2) @(negedge clk);
    tb_v[0] = 1'b1;
    #1;
    chk("reset_rsp_valid", o_rsp_valid, 0);
    chk("reset_rsp_byte",  o_rsp_byte,  0);
    chk("reset_rsp_id",    o_rsp_id,    0);
    chk("reset_rsp_last",  o_rsp_last,  0);
    chk("reset_busy",      o_busy,      0);
    chk("reset_req_ready", o_req_ready, 0);
    tb_v[0] = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;

    // Single byte with one-cycle latency, then drop after consume
    expect_rsp(8'h00, 0, 1'b1);
    drive(0, 8'h00, 1'b1, w0);
    chk("single_latency_valid", o_rsp_valid, 1);
    @(posedge clk);
    #1;
    chk("single_valid_drops", o_rsp_valid, 0);

    // Single byte from req1 so round robin restarts at req0
    expect_rsp(8'h01, 1, 1'b1);
    drive(1, 8'h01, 1'b1, w1);

    // Round robin, both streaming single-byte requests
    expect_rsp(8'h53, 0, 1'b1);
    expect_rsp(8'h01, 1, 1'b1);
    expect_rsp(8'h53, 0, 1'b1);
    expect_rsp(8'h01, 1, 1'b1);
    c0 = cyc;
    fork
      begin drive(0, 8'h53, 1'b1, w0); drive(0, 8'h53, 1'b1, w0); end
      begin drive(1, 8'h01, 1'b1, w1); drive(1, 8'h01, 1'b1, w1); end
    join
    chk("rr_no_bubble_cycles", cyc - c0, 4);

    // Move rr_ptr to req1 so it wins the first arbitration of the burst
    expect_rsp(8'h00, 0, 1'b1);
    drive(0, 8'h00, 1'b1, w0);

    // Burst lock: req1 four bytes, req0 waiting throughout
    expect_rsp(8'h10, 1, 1'b0);
    expect_rsp(8'h11, 1, 1'b0);
    expect_rsp(8'h12, 1, 1'b0);
    expect_rsp(8'h13, 1, 1'b1);
    expect_rsp(8'h53, 0, 1'b1);
    fork
      begin
        drive(1, 8'h10, 1'b0, w1);
        drive(1, 8'h11, 1'b0, w1);
        drive(1, 8'h12, 1'b0, w1);
        drive(1, 8'h13, 1'b1, w1);
      end
      begin drive(0, 8'h53, 1'b1, w0); end
    join
    chk("lock_req0_stall_cycles", w0, 4);

    // Backpressure: response 0x16 held for 3 cycles, requests blocked
    @(posedge clk);
    #1;
    i_rsp_ready = 1'b0;
    expect_rsp(8'hFF, 1, 1'b1);
    drive(1, 8'hFF, 1'b1, w1);
    expect_rsp(8'h9A, 0, 1'b1);
    expect_rsp(8'h53, 0, 1'b1);
    fork
      begin drive(0, 8'h9A, 1'b1, w0); drive(0, 8'h53, 1'b1, w0); end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_rsp_valid", o_rsp_valid, 1);
          chk("bp_rsp_byte",  o_rsp_byte,  8'h16);
          chk("bp_rsp_id",    o_rsp_id,    1);
          chk("bp_req_ready", o_req_ready, 0);
        end
        @(posedge clk);
        #1;
        i_rsp_ready = 1'b1;
      end
    join

    // Exhaustive S-box sweep through req1
    for (int v = 0; v < 256; v++) begin
      expect_rsp(8'(v), 1, 1'b1);
      drive(1, 8'(v), 1'b1, w1);
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a locked burst
    expect_rsp(8'h10, 1, 1'b0);
    drive(1, 8'h10, 1'b0, w1);
    drive(1, 8'h11, 1'b0, w1);
    tb_v[1] = 1'b1;
    tb_b[1] = 8'h12;
    tb_l[1] = 1'b0;
    tb_v[0] = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("midrst_rsp_valid", o_rsp_valid, 0);
    chk("midrst_rsp_byte",  o_rsp_byte,  0);
    chk("midrst_rsp_id",    o_rsp_id,    0);
    chk("midrst_rsp_last",  o_rsp_last,  0);
    chk("midrst_busy",      o_busy,      0);
    chk("midrst_req_ready", o_req_ready, 0);
    chk("midrst_sb_empty",  sb.size(),   0);
    tb_v[0] = 1'b0;
    tb_v[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_rsp(8'h00, 0, 1'b1);
    drive(0, 8'h00, 1'b1, w0);
    chk("postrst_grant_immediate", w0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
